// File: rtl/glyph_blitter.sv
// Positions and scales a 5x5 glyph over the VGA raster: drives the ROM row index, colours the returned row bits.
// Latency: 2 cycles from pix_x/pix_y/video_on to rgb/pix_valid. Backpressure: none, one pixel per clock.
// Optional blink, enabled by defining GLYPH_BLINK_EN.
module glyph_blitter #(
    parameter int SCALE_LOG2 = 2,
    parameter int ORG_X_INIT = 300,
    parameter int ORG_Y_INIT = 220,
    parameter int BLINK_BITS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       video_on,
    input  logic       frame_start,
    input  logic       org_load,
    input  logic [9:0] org_x_in,
    input  logic [9:0] org_y_in,
    input  logic [7:0] fg_color,
    input  logic [7:0] bg_color,
    output logic [2:0] rom_row,
    input  logic [4:0] rom_code,
    output logic [7:0] rgb,
    output logic       pix_valid
);

    localparam logic [10:0] GLYPH_SPAN = 11'(5 << SCALE_LOG2);
    localparam logic [9:0]  INIT_X     = 10'(ORG_X_INIT);
    localparam logic [9:0]  INIT_Y     = 10'(ORG_Y_INIT);

    logic [9:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic [9:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;

    logic [2:0] rom_row_q, rom_row_d;
    logic [2:0] col_q, col_d;
    logic       hit_q, hit_d;
    logic       von_q, von_d;
    logic [7:0] rgb_q, rgb_d;
    logic       pix_valid_q, pix_valid_d;

    logic [10:0] x_end, y_end;
    logic [9:0]  dx, dy;
    logic        in_x, in_y;
    logic [2:0]  bit_sel;
    logic        blink_hide;

`ifdef GLYPH_BLINK_EN
    logic [BLINK_BITS-1:0] blink_q, blink_d;

    always_comb begin
        blink_d = blink_q;
        if (frame_start) begin
            blink_d = blink_q + BLINK_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blink_hide = blink_q[BLINK_BITS-1];
`else
    assign blink_hide = 1'b0 & (BLINK_BITS > 0);
`endif

    // Same-cycle load and frame_start: active picks up the old pending value.
    always_comb begin
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        if (org_load) begin
            pend_x_d = org_x_in;
            pend_y_d = org_y_in;
        end
        if (frame_start) begin
            act_x_d = pend_x_q;
            act_y_d = pend_y_q;
        end
    end

    // 11-bit window ends so a glyph near 1023 is clipped rather than wrapped to 0.
    always_comb begin
        x_end = {1'b0, act_x_q} + GLYPH_SPAN;
        y_end = {1'b0, act_y_q} + GLYPH_SPAN;
        in_x  = ({1'b0, pix_x} >= {1'b0, act_x_q}) && ({1'b0, pix_x} < x_end);
        in_y  = ({1'b0, pix_y} >= {1'b0, act_y_q}) && ({1'b0, pix_y} < y_end);
        dx    = pix_x - act_x_q;
        dy    = pix_y - act_y_q;

        rom_row_d = in_y ? 3'(dy >> SCALE_LOG2) : 3'd0;
        col_d     = in_x ? 3'(dx >> SCALE_LOG2) : 3'd0;
        hit_d     = in_x & in_y & video_on & ~blink_hide;
        von_d     = video_on;
    end

    always_comb begin
        bit_sel     = 3'd4 - col_q;
        rgb_d       = 8'h00;
        pix_valid_d = von_q;
        if (von_q) begin
            rgb_d = (hit_q && rom_code[bit_sel]) ? fg_color : bg_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_x_q     <= INIT_X;
            act_y_q     <= INIT_Y;
            pend_x_q    <= INIT_X;
            pend_y_q    <= INIT_Y;
            rom_row_q   <= 3'd0;
            col_q       <= 3'd0;
            hit_q       <= 1'b0;
            von_q       <= 1'b0;
            rgb_q       <= 8'h00;
            pix_valid_q <= 1'b0;
        end else begin
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            rom_row_q   <= rom_row_d;
            col_q       <= col_d;
            hit_q       <= hit_d;
            von_q       <= von_d;
            rgb_q       <= rgb_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign rom_row   = rom_row_q;
    assign rgb       = rgb_q;
    assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_glyph_blitter.sv
// Scoreboard bench for glyph_blitter: a reference model predicts rom_row at once and rgb/pix_valid one step later.
module tb_glyph_blitter;

    localparam int S  = 2;
    localparam int BB = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] pix_x, pix_y, org_x_in, org_y_in;
    logic       video_on, frame_start, org_load;
    logic [7:0] fg_color, bg_color;
    logic [2:0] rom_row;
    logic [4:0] rom_code;
    logic [7:0] rgb;
    logic       pix_valid;

    always #5 clk = ~clk;

    glyph_blitter #(
        .SCALE_LOG2(S), .ORG_X_INIT(300), .ORG_Y_INIT(220), .BLINK_BITS(BB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
        .frame_start(frame_start), .org_load(org_load), .org_x_in(org_x_in),
        .org_y_in(org_y_in), .fg_color(fg_color), .bg_color(bg_color),
        .rom_row(rom_row), .rom_code(rom_code), .rgb(rgb), .pix_valid(pix_valid)
    );

    // 'X' glyph
    function automatic logic [4:0] glyph_row(input int r);
        case (r)
            0: return 5'b10001;
            1: return 5'b01010;
            2: return 5'b00100;
            3: return 5'b01010;
            4: return 5'b10001;
            default: return 5'b00000;
        endcase
    endfunction

    always_comb rom_code = glyph_row(int'(rom_row));

    typedef struct {
        logic [7:0] rgb;
        logic       vld;
        int         x;
        int         y;
    } exp_t;

    exp_t  q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    m_ox, m_oy, m_px, m_py, m_blink;
    string cur_test;

    task automatic model_reset();
        m_ox = 300; m_oy = 220; m_px = 300; m_py = 220; m_blink = 0;
        q.delete();
    endtask

    task automatic step(input int x, input int y, input logic von,
                        input logic ld = 1'b0, input int lx = 0, input int ly = 0,
                        input logic fs = 1'b0);
        bit   inx, iny, hit;
        int   row, col;
        logic [4:0] code;
        exp_t e;
        pix_x = 10'(x); pix_y = 10'(y); video_on = von;
        org_load = ld; org_x_in = 10'(lx); org_y_in = 10'(ly); frame_start = fs;

        inx = (x >= m_ox) && (x < m_ox + (5 << S));
        iny = (y >= m_oy) && (y < m_oy + (5 << S));
        row = iny ? (y - m_oy) >> S : 0;
        col = inx ? (x - m_ox) >> S : 0;
        hit = inx && iny && (von == 1'b1);
`ifdef GLYPH_BLINK_EN
        if (m_blink >= (1 << (BB - 1))) hit = 1'b0;
`endif
        code  = glyph_row(row);
        e.rgb = (von !== 1'b1) ? 8'h00 : (hit && code[4 - col]) ? fg_color : bg_color;
        e.vld = von;
        e.x = x; e.y = y;
        q.push_back(e);

        @(posedge clk); #1;
        if (fs) begin
            m_ox = m_px; m_oy = m_py;
            m_blink = (m_blink + 1) % (1 << BB);
        end
        if (ld) begin
            m_px = lx; m_py = ly;
        end

        n_vec++;
        if (rom_row !== 3'(row)) begin
            n_err++;
            $display("FAIL %s rom_row (%0d,%0d): got %0d expected %0d", cur_test, x, y, rom_row, row);
        end
        if (q.size() >= 2) begin
            e = q.pop_front();
            n_vec++;
            if (rgb !== e.rgb || pix_valid !== e.vld) begin
                n_err++;
                $display("FAIL %s rgb (%0d,%0d): got %h/%b expected %h/%b",
                         cur_test, e.x, e.y, rgb, pix_valid, e.rgb, e.vld);
            end
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        rst_n = 1'b0;
        pix_x = '0; pix_y = '0; video_on = 1'b0; frame_start = 1'b0;
        org_load = 1'b0; org_x_in = '0; org_y_in = '0;
        fg_color = 8'hE0; bg_color = 8'h03;
        model_reset();
        #12;
        n_vec++;
        if (rom_row !== 3'd0 || rgb !== 8'h00 || pix_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset outputs: got row=%0d rgb=%h vld=%b expected 0/00/0", rom_row, rgb, pix_valid);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_row_edges();
        cur_test = "row_edges";
        q.delete();
        step(300, 220, 1'b1);
        step(304, 220, 1'b1);
        step(316, 220, 1'b1);
        step(319, 220, 1'b1);
        step(320, 220, 1'b1);
        step(299, 220, 1'b1);
        step(308, 239, 1'b1);
        step(308, 240, 1'b1);
        step(308, 219, 1'b1);
        step(310, 230, 1'b1);
        step(310, 230, 1'b0);
        step(300, 220, 1'b0);
        step(0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        fg_color = 8'h1C; bg_color = 8'h40;
        step(0, 0, 1'b0);
        q.delete();
        for (int y = 218; y <= 241; y += 3) begin
            for (int x = 296; x <= 323; x++) begin
                step(x, y, 1'b1);
            end
        end
        step(0, 0, 1'b0);
    endtask

    task automatic test_origin();
        cur_test = "origin";
        q.delete();
        step(300, 220, 1'b1, 1'b1, 100, 50);
        step(300, 220, 1'b1);
        step(100, 50, 1'b1);
        step(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        step(100, 50, 1'b1);
        step(300, 220, 1'b1);
        step(0, 0, 1'b0, 1'b1, 400, 300, 1'b1);
        step(400, 300, 1'b1);
        step(100, 50, 1'b1);
        step(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        step(400, 300, 1'b1);
        step(0, 0, 1'b0, 1'b1, 10, 10);
        step(0, 0, 1'b0, 1'b1, 1010, 600);
        step(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        step(10, 10, 1'b1);
        step(1012, 600, 1'b1);
        step(1023, 600, 1'b1);
        step(1022, 614, 1'b1);
        step(2, 600, 1'b1);
        step(5, 600, 1'b1);
        step(0, 0, 1'b0);
    endtask

    task automatic test_mid_reset();
        cur_test = "mid_reset";
        step(1012, 600, 1'b1);
        step(1012, 600, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (rom_row !== 3'd0 || rgb !== 8'h00 || pix_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset outputs: got row=%0d rgb=%h vld=%b expected 0/00/0", rom_row, rgb, pix_valid);
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        step(300, 220, 1'b1);
        step(1012, 600, 1'b1);
        step(316, 236, 1'b1);
        step(0, 0, 1'b0);
    endtask

`ifdef GLYPH_BLINK_EN
    task automatic test_blink();
        cur_test = "blink";
        q.delete();
        for (int f = 0; f < 6; f++) begin
            step(300, 220, 1'b1);
            step(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        end
        step(0, 0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_row_edges();
        test_back_to_back();
        test_origin();
        test_mid_reset();
`ifdef GLYPH_BLINK_EN
        test_blink();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
